// File: rtl/fta_bus_pkg.sv
// Shared types and constants for the FTA I/O router.
// Contents: 32-bit command request/response structs, the router state
// encoding, the default device window base and the idle request value.
package fta_bus_pkg;

    typedef struct packed {
        logic        cyc;
        logic        stb;
        logic        we;
        logic [3:0]  sel;
        logic [7:0]  tid;
        logic [31:0] padr;
        logic [31:0] dat;
    } fta_cmd_request32_t;

    typedef struct packed {
        logic        ack;
        logic        err;
        logic [7:0]  tid;
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  pri;
    } fta_cmd_response32_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        ERR   = 2'd3
    } router_state_t;

    localparam logic [31:0] FTA_IO_BASE = 32'hFEE00000;

    // An idle channel parks its address at all-ones so no device decodes it.
    localparam fta_cmd_request32_t FTA_IDLE_REQ = '{
        cyc: 1'b0, stb: 1'b0, we: 1'b0, sel: 4'h0, tid: 8'h00,
        padr: 32'hFFFFFFFF, dat: 32'h0
    };

endpackage

// File: rtl/fta_io_decode32.sv
// Combinational address decoder.
// Ports: padr (physical address in), hit (one-hot channel select),
//        idx (binary channel index), miss (no window matched).
// Overlapping windows resolve to the lowest channel number.
module fta_io_decode32 #(
    parameter int          CHANNELS = 2,
    parameter int          IW       = 1,
    parameter logic [31:0] CH_BASE [CHANNELS] = '{32'hFEE00000, 32'hFEE10000},
    parameter logic [31:0] CH_MASK [CHANNELS] = '{32'hFFFF0000, 32'hFFFF0000}
) (
    input  logic [31:0]         padr,
    output logic [CHANNELS-1:0] hit,
    output logic [IW-1:0]       idx,
    output logic                miss
);

    // Scan high to low so the lowest matching channel is written last.
    always_comb begin
        hit  = '0;
        idx  = '0;
        miss = 1'b1;
        for (int k = CHANNELS - 1; k >= 0; k--) begin
            if ((padr & CH_MASK[k]) == (CH_BASE[k] & CH_MASK[k])) begin
                hit    = '0;
                hit[k] = 1'b1;
                idx    = IW'(k);
                miss   = 1'b0;
            end
        end
    end

endmodule

// File: rtl/fta_io_router32.sv
// Routes a 32-bit bridge request to one device channel and watches it
// with a timeout; unmapped or timed-out accesses produce err_resp.
// Ports: clk_i, rst_i (sync, active-high), req (from bridge),
//        chresp (device responses, tapped), ch_req (per-channel requests),
//        err_resp (one-cycle error response), busy (transaction outstanding).
//
// state | meaning
// IDLE  | waiting for a new request
// ISSUE | request latched; strobe presented to the channel next cycle
// WAIT  | cyc held, watchdog counting, waiting for matching ack/err
// ERR   | unmapped or timed out; error response presented next cycle
module fta_io_router32
    import fta_bus_pkg::*;
#(
    parameter int          CHANNELS = 2,
    parameter int          TIMEOUT  = 255,
    parameter logic [31:0] CH_BASE [CHANNELS] = '{32'hFEE00000, 32'hFEE10000},
    parameter logic [31:0] CH_MASK [CHANNELS] = '{32'hFFFF0000, 32'hFFFF0000}
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  fta_cmd_request32_t  req,
    input  fta_cmd_response32_t chresp   [CHANNELS],
    output fta_cmd_request32_t  ch_req   [CHANNELS],
    output fta_cmd_response32_t err_resp,
    output logic                busy
);

    localparam int             CW  = $clog2(TIMEOUT + 1);
    localparam int             IW  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam logic [CW-1:0]  TMO = CW'(TIMEOUT);

    router_state_t       state, state_d;
    fta_cmd_request32_t  req_q;
    logic [IW-1:0]       ch_q;
    logic [CW-1:0]       cnt;
    logic                cyc_low_seen;
    logic [7:0]          last_tid;
    logic [CHANNELS-1:0] hit;
    logic [IW-1:0]       hit_idx;
    logic                miss;
    logic                new_req;
    logic                rsp_match;
    logic                tmo;
    logic                unused_bits;
    fta_cmd_request32_t  ch_req_d [CHANNELS];
    fta_cmd_response32_t err_resp_d;

    fta_io_decode32 #(
        .CHANNELS (CHANNELS),
        .IW       (IW),
        .CH_BASE  (CH_BASE),
        .CH_MASK  (CH_MASK)
    ) u_decode (
        .padr (req.padr),
        .hit  (hit),
        .idx  (hit_idx),
        .miss (miss)
    );

    // A level-held cyc with an unchanged tid is the same transaction.
    assign new_req = req.cyc & req.stb & (cyc_low_seen | (req.tid != last_tid));
    assign tmo     = (cnt == TMO);
    assign busy    = (state != IDLE);

    always_comb begin
        rsp_match = 1'b0;
        for (int k = 0; k < CHANNELS; k++) begin
            if ((IW'(k) == ch_q) && (chresp[k].ack | chresp[k].err) &&
                (chresp[k].tid == req_q.tid))
                rsp_match = 1'b1;
        end
    end

    always_comb begin
        unused_bits = ^hit;
        for (int k = 0; k < CHANNELS; k++)
            unused_bits = unused_bits ^ (^{chresp[k].adr, chresp[k].dat, chresp[k].pri});
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) state <= IDLE;
        else       state <= state_d;
    end

    always_comb begin
        state_d = state;
        case (state)
            IDLE:    if (new_req) state_d = miss ? ERR : ISSUE;
            ISSUE:   state_d = WAIT;
            WAIT:    if (rsp_match) state_d = IDLE;
                     else if (tmo)  state_d = ERR;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are registered, so each appears the cycle after its state.
    always_comb begin
        for (int k = 0; k < CHANNELS; k++) begin
            ch_req_d[k] = FTA_IDLE_REQ;
            if (IW'(k) == ch_q) begin
                if (state == ISSUE) begin
                    ch_req_d[k]     = req_q;
                    ch_req_d[k].cyc = 1'b1;
                    ch_req_d[k].stb = 1'b1;
                end else if (state == WAIT && !rsp_match && !tmo) begin
                    ch_req_d[k]     = req_q;
                    ch_req_d[k].cyc = 1'b1;
                    ch_req_d[k].stb = 1'b0;
                end
            end
        end
        err_resp_d = '0;
        if (state == ERR) begin
            err_resp_d.err = 1'b1;
            err_resp_d.tid = req_q.tid;
            err_resp_d.adr = req_q.padr;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            req_q        <= FTA_IDLE_REQ;
            ch_q         <= '0;
            cnt          <= '0;
            cyc_low_seen <= 1'b1;
            last_tid     <= '0;
            err_resp     <= '0;
            for (int k = 0; k < CHANNELS; k++) ch_req[k] <= FTA_IDLE_REQ;
        end else begin
            if (state == IDLE && new_req) begin
                req_q        <= req;
                ch_q         <= hit_idx;
                last_tid     <= req.tid;
                cyc_low_seen <= 1'b0;
            end else if (!req.cyc) begin
                cyc_low_seen <= 1'b1;
            end
            if (state == ISSUE)              cnt <= '0;
            else if (state == WAIT && !tmo)  cnt <= cnt + 1'b1;
            ch_req   <= ch_req_d;
            err_resp <= err_resp_d;
        end
    end

endmodule

// File: tb/tb_fta_io_router32.sv
module tb_fta_io_router32;
    import fta_bus_pkg::*;

    logic                clk_i = 1'b0;
    logic                rst_i = 1'b1;
    fta_cmd_request32_t  req;
    fta_cmd_response32_t chresp   [2];
    fta_cmd_request32_t  ch_req   [2];
    fta_cmd_response32_t err_resp;
    logic                busy;

    int total = 0;
    int bad   = 0;
    int err_cnt  = 0;
    int stb0_cnt = 0;
    int stb1_cnt = 0;
    int cycles;

    fta_io_router32 #(.CHANNELS(2), .TIMEOUT(4)) dut (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .req      (req),
        .chresp   (chresp),
        .ch_req   (ch_req),
        .err_resp (err_resp),
        .busy     (busy)
    );

    always #5 clk_i = ~clk_i;

    always @(negedge clk_i) begin
        if (err_resp.err === 1'b1)  err_cnt++;
        if (ch_req[0].stb === 1'b1) stb0_cnt++;
        if (ch_req[1].stb === 1'b1) stb1_cnt++;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got=hang exp=finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive_req(input logic [31:0] padr, input logic [7:0] tid);
        req      = FTA_IDLE_REQ;
        req.cyc  = 1'b1;
        req.stb  = 1'b1;
        req.padr = padr;
        req.tid  = tid;
    endtask

    task automatic drop_req();
        req = FTA_IDLE_REQ;
    endtask

    task automatic set_ack(input int ch, input logic [7:0] tid);
        chresp[0] = '0;
        chresp[1] = '0;
        chresp[ch].ack = 1'b1;
        chresp[ch].tid = tid;
    endtask

    task automatic clr_ack();
        chresp[0] = '0;
        chresp[1] = '0;
    endtask

    initial begin
        req = FTA_IDLE_REQ;
        clr_ack();

        // reset values
        tick(); tick();
        check("rst_padr0", ch_req[0].padr, 32'hFFFFFFFF);
        check("rst_padr1", ch_req[1].padr, 32'hFFFFFFFF);
        check("rst_cyc1", 32'(ch_req[1].cyc), 32'd0);
        check("rst_err", 32'(err_resp.err), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        rst_i = 1'b0;
        tick();

        // read hit on channel 1, acked three cycles after the strobe
        drive_req(32'hFEE10004, 8'd5);
        tick();
        drop_req();
        check("hit_busy_issue", 32'(busy), 32'd1);
        check("hit_stb_early", 32'(ch_req[1].stb), 32'd0);
        tick();
        check("hit_stb", 32'(ch_req[1].stb), 32'd1);
        check("hit_padr", ch_req[1].padr, 32'hFEE10004);
        check("hit_ch0_idle", 32'(ch_req[0].cyc), 32'd0);
        tick();
        check("hit_stb_drop", 32'(ch_req[1].stb), 32'd0);
        check("hit_cyc_hold", 32'(ch_req[1].cyc), 32'd1);
        tick();
        set_ack(1, 8'd5);
        tick();
        clr_ack();
        check("hit_busy_done", 32'(busy), 32'd0);
        check("hit_cyc_done", 32'(ch_req[1].cyc), 32'd0);
        tick();
        check("hit_no_err", 32'(err_cnt), 32'd0);
        check("hit_stb_count", 32'(stb1_cnt), 32'd1);

        // unmapped access
        drive_req(32'h00001000, 8'd7);
        tick();
        drop_req();
        check("unm_busy", 32'(busy), 32'd1);
        tick();
        check("unm_err", 32'(err_resp.err), 32'd1);
        check("unm_ack", 32'(err_resp.ack), 32'd0);
        check("unm_tid", 32'(err_resp.tid), 32'd7);
        check("unm_adr", err_resp.adr, 32'h00001000);
        tick();
        check("unm_err_once", 32'(err_resp.err), 32'd0);
        check("unm_err_count", 32'(err_cnt), 32'd1);
        check("unm_no_stb", 32'(stb0_cnt + stb1_cnt), 32'd1);

        // timeout on channel 0: error six cycles after the strobe
        drive_req(32'hFEE00010, 8'd9);
        tick();
        drop_req();
        tick();
        check("tmo_stb", 32'(ch_req[0].stb), 32'd1);
        cycles = 0;
        while (err_resp.err !== 1'b1 && cycles < 20) begin
            tick();
            cycles++;
        end
        check("tmo_latency", 32'(cycles), 32'd6);
        check("tmo_tid", 32'(err_resp.tid), 32'd9);
        check("tmo_adr", err_resp.adr, 32'hFEE00010);
        check("tmo_cyc_dropped", 32'(ch_req[0].cyc), 32'd0);
        tick();
        check("tmo_err_count", 32'(err_cnt), 32'd2);
        check("tmo_busy", 32'(busy), 32'd0);

        // ack arriving in the same cycle the counter reaches TIMEOUT
        drive_req(32'hFEE00020, 8'd11);
        tick();
        drop_req();
        tick();
        check("col_stb", 32'(ch_req[0].stb), 32'd1);
        tick(); tick(); tick(); tick();
        check("col_cyc_still", 32'(ch_req[0].cyc), 32'd1);
        set_ack(0, 8'd11);
        tick();
        clr_ack();
        check("col_busy", 32'(busy), 32'd0);
        check("col_cyc_drop", 32'(ch_req[0].cyc), 32'd0);
        tick(); tick();
        check("col_no_err", 32'(err_cnt), 32'd2);

        // wrong tid and wrong channel acks are ignored
        drive_req(32'hFEE00030, 8'd4);
        tick();
        drop_req();
        tick();
        set_ack(0, 8'd3);
        tick();
        check("wtid_busy", 32'(busy), 32'd1);
        set_ack(1, 8'd4);
        tick();
        check("wch_busy", 32'(busy), 32'd1);
        check("wch_cyc", 32'(ch_req[0].cyc), 32'd1);
        set_ack(0, 8'd4);
        tick();
        clr_ack();
        check("match_busy", 32'(busy), 32'd0);
        tick(); tick();
        check("match_no_err", 32'(err_cnt), 32'd2);
        check("match_stb0_count", 32'(stb0_cnt), 32'd3);

        // held cyc with the same tid must not reissue
        drive_req(32'hFEE10040, 8'd6);
        tick();
        tick();
        set_ack(1, 8'd6);
        tick();
        clr_ack();
        for (int i = 0; i < 5; i++) tick();
        check("held_stb_count", 32'(stb1_cnt), 32'd2);
        check("held_busy", 32'(busy), 32'd0);

        // a new tid on the still-held cyc is a new transaction; reset it in WAIT
        drive_req(32'hFEE10044, 8'd8);
        tick();
        check("newtid_busy", 32'(busy), 32'd1);
        drop_req();
        tick();
        check("newtid_stb", 32'(ch_req[1].stb), 32'd1);
        tick();
        check("rstw_cyc_before", 32'(ch_req[1].cyc), 32'd1);
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        check("rstw_cyc", 32'(ch_req[1].cyc), 32'd0);
        check("rstw_padr", ch_req[1].padr, 32'hFFFFFFFF);
        check("rstw_busy", 32'(busy), 32'd0);
        check("rstw_err", 32'(err_resp.err), 32'd0);
        for (int i = 0; i < 8; i++) tick();
        check("rstw_no_err", 32'(err_cnt), 32'd2);
        check("rstw_idle", 32'(busy), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fta_io_router32.md
# fta_io_router32

Downstream neighbour of the 128-to-32 I/O bridge. Takes the bridge's registered 32-bit request and decodes its physical address into one of CHANNELS device windows. It drives exactly one device channel per transaction and supervises that transaction with a timeout watchdog. Unmapped or timed-out accesses produce an error response on a dedicated response port, which is wired as one extra input of the bridge's response buffer.

## Interface
Parameters:
- CHANNELS, 2: number of device channels.
- TIMEOUT, 255: cycles allowed between issue and ack before an error is raised; legal range 1..65535.
- CH_BASE, {32'hFEE00000, 32'hFEE10000}: per-channel base address, array [CHANNELS].
- CH_MASK, {32'hFFFF0000, 32'hFFFF0000}: per-channel compare mask, array [CHANNELS].

Ports:
- clk_i  in  1  sole clock; all logic is on the rising edge.
- rst_i  in  1  reset; synchronous, active-high.
- req  in  fta_cmd_request32_t  request from the bridge.
- chresp  in  fta_cmd_response32_t [CHANNELS]  device responses; this port only taps them, the bridge's response buffer also consumes them.
- ch_req  out  fta_cmd_request32_t [CHANNELS]  per-channel requests.
- err_resp  out  fta_cmd_response32_t  error response for unmapped or timed-out accesses.
- busy  out  1  high while a transaction is outstanding.

## Operation
- Decode: channel k hits when (req.padr & CH_MASK[k]) == (CH_BASE[k] & CH_MASK[k]). The lowest k wins on overlapping windows.
- New request: req.cyc & req.stb in IDLE, and either (req.cyc was low since the last accept) or (req.tid != last accepted tid). A level-held cyc never reissues the same transaction.
- FSM:
  - IDLE: on a new request that hits channel k, latch req, k, and tid, then go to ISSUE. On a new request with no hit, go to ERR.
  - ISSUE: ch_req[k] carries the latched request with cyc=1, stb=1 for this one cycle. Clear the counter, then go to WAIT.
  - WAIT: ch_req[k].cyc stays 1 and stb=0; the counter increments each cycle.
    - If chresp[k].ack or chresp[k].err, with tid equal to the latched tid, drop cyc and go to IDLE.
    - Otherwise, when the counter reaches TIMEOUT, drop cyc and go to ERR.
  - ERR: err_resp for one cycle, with err=1, ack=0, tid = latched tid, adr = latched padr, dat=0, pri=0. Then go to IDLE.
- Responses from other channels, or with a non-matching tid, are ignored.
- Counter width is $clog2(TIMEOUT+1). It saturates and never wraps.
- Non-selected ch_req entries hold the idle value at all times.

## Timing
- Reset values, on the cycle after rst_i is sampled high:
  - every ch_req: all fields 0, padr=32'hFFFFFFFF.
  - err_resp: all fields 0.
  - busy=0; FSM=IDLE; counter=0.
  - The last-tid latch is cleared, so the first request after reset is always new.
- Issue latency: a request sampled at edge n shows ch_req[k].stb high after edge n+1.
- Unmapped latency: err_resp.err is high after edge n+1, for exactly one cycle.
- Timeout: if the ack never arrives, err_resp.err is high TIMEOUT+2 cycles after the issue cycle.
- Ack arriving in the same cycle the counter reaches TIMEOUT: the ack wins and no error is raised.
- busy is high from the ISSUE (or ERR) cycle through the cycle before returning to IDLE.
- A request arriving while busy is not accepted. It is evaluated once the FSM is back in IDLE.
- rst_i mid-transaction: abort with no err_resp, and drop cyc on the next edge.

## Structure
- fta_bus_pkg holds:
  - a router-state enum (IDLE, ISSUE, WAIT, ERR);
  - an FTA_IO_BASE default constant;
  - the idle-request constant, padr=32'hFFFFFFFF and all else 0.
- One sub-module: fta_io_decode32, a combinational address-to-one-hot/index decoder with a miss flag, parameterised by CHANNELS, CH_BASE, and CH_MASK.
- The FSM and watchdog live in the top module.

## Test plan
- Read hit, channel 1:
  - Stimulus: req padr=32'hFEE10004, tid=5.
  - Response: ch_req[1].stb pulses one cycle; chresp[1].ack with tid=5 three cycles later leads to busy=0 and no err.
- Unmapped:
  - Stimulus: padr=32'h00001000, tid=7.
  - Response: err_resp.err=1 for one cycle with tid=7 and adr=32'h00001000; no ch_req stb.
- Timeout with TIMEOUT=4:
  - Stimulus: access to channel 0, never acked.
  - Response: err_resp.err arrives 6 cycles after stb, then cyc drops.
- Ack/timeout collision:
  - Stimulus: ack arrives exactly at counter==TIMEOUT.
  - Response: no err_resp, and a clean return to IDLE.
- Wrong-tid and wrong-channel ack:
  - Stimulus: chresp[0].ack with tid=3 while waiting on tid=4, and an ack on channel 1.
  - Response: both ignored; the transaction completes only on the matching ack.
- Held cyc and reset:
  - Stimulus: req.cyc held high with the same tid after completion.
  - Response: no second issue.
  - Stimulus: assert rst_i in WAIT.
  - Response: all outputs are at reset values next cycle, with no err.
